clint: RTL and testbench
========================

CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter INT_FLAG_W, default 8, width of the external interrupt request vector.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising edge), then rst input 1 (asynchronous, active-high).
REQ-003 SHALL have ports:
- int_flag_i  in  INT_FLAG_W  interrupt requests; bit0 = timer, others = external.
- inst_i  in  32  instruction in decode.
- inst_addr_i  in  32  PC of inst_i.
- jump_flag_i  in  1  ex is redirecting this cycle.
- jump_addr_i  in  32  ex redirect target.
- div_started_i  in  1  multi-cycle divide in flight.
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  current CSR values.
- global_int_en_i  in  1  mstatus.MIE.
- hold_flag_o  out  1  stall whole pipeline.
- we_o  out  1  CSR write strobe.
- waddr_o  out  32  CSR write address, zero-extended 12-bit.
- raddr_o  out  32  CSR read address, tied 0.
- data_o  out  32  CSR write data.
- int_assert_o  out  1  redirect pulse.
- int_addr_o  out  32  redirect target.

Function
REQ-004 SHALL decode ecall = 32'h00000073, ebreak = 32'h00100073, mret = 32'h30200073 on inst_i.
REQ-005 SHALL flag an async request when int_flag_i != 0, global_int_en_i = 1 and div_started_i = 0; a request raised while div_started_i = 1 SHALL be taken on the first cycle after it drops, if int_flag_i is still non-zero.
REQ-006 Entry priority in IDLE SHALL be: ecall/ebreak > mret > async interrupt; only one entry per IDLE cycle.
REQ-007 SHALL have trap FSM states IDLE, SYNC, ASYNC, MRET.
- IDLE->SYNC on ecall/ebreak; IDLE->ASYNC on async request; IDLE->MRET on mret.
- All three return to IDLE after their write sequence completes.
REQ-008 SHALL latch the cause and the return PC on entry:
- SYNC: mepc = inst_addr_i; mcause = 11 (ecall) or 3 (ebreak).
- ASYNC: mepc = jump_addr_i if jump_flag_i else inst_addr_i; mcause = 32'h80000007 if int_flag_i[0], else 32'h8000000B.
REQ-009 SYNC/ASYNC SHALL issue one CSR write per cycle, in order:
1. MEPC (12'h341) = latched PC.
2. MSTATUS (12'h300) = csr_mstatus_i with bit7 (MPIE) = old bit3 and bit3 = 0.
3. MCAUSE (12'h342) = latched cause.
Then int_assert_o = 1 with int_addr_o = csr_mtvec_i for exactly one cycle, and return to IDLE.
REQ-010 MRET SHALL:
- write MSTATUS with bit3 = old bit7 and bit7 = 1 in one cycle;
- on the next cycle pulse int_assert_o with int_addr_o = csr_mepc_i;
- return to IDLE.
REQ-011 Entry latency SHALL be one cycle: first we_o in the cycle after the triggering inst_i/int_flag_i is sampled.
REQ-012 hold_flag_o SHALL be asserted combinationally in the triggering cycle and in every non-IDLE cycle, including the int_assert_o cycle.
REQ-013 Triggers arriving while not IDLE SHALL be ignored.
REQ-014 When we_o = 0 and int_assert_o = 0: waddr_o, data_o and int_addr_o SHALL be 0.

Reset
REQ-015 rst asserted at any time, including mid-sequence, SHALL immediately force:
- state = IDLE;
- latched PC and cause = 0;
- all outputs 0 (hold_flag_o driven by IDLE decode only).
REQ-016 No partial write sequence SHALL resume after reset release.

Structure
REQ-017 SHALL keep CSR addresses, the ecall/ebreak/mret encodings, the mcause codes and the FSM state encodings in the shared defines package.
REQ-018 SHALL be one module without sub-modules; the FSM and the write sequencer SHALL share a single state register.

Verification
REQ-019 ecall at PC 0x100, mtvec = 0x200, mstatus = 0x8:
- cycles 1-3 write MEPC = 0x100, MSTATUS = 0x80, MCAUSE = 11;
- cycle 4: int_assert_o = 1, int_addr_o = 0x200;
- hold_flag_o high throughout.
REQ-020 int_flag_i = 0x01, MIE = 1, jump_flag_i = 1, jump_addr_i = 0x340:
- MEPC = 0x340, MCAUSE = 0x80000007.
- Repeat with int_flag_i = 0x04 and no jump: MEPC = inst_addr_i, MCAUSE = 0x8000000B.
REQ-021 mret with mstatus = 0x80, mepc = 0x104:
- MSTATUS written = 0x88;
- next cycle int_assert_o = 1, int_addr_o = 0x104.
REQ-022 int_flag_i held at 0x02 with div_started_i = 1 for 5 cycles: no we_o. Drop div_started_i: the MEPC write occurs on the next cycle. With MIE = 0: no response at all.
REQ-023 ecall and int_flag_i in the same cycle: the sync sequence runs, and the interrupt is ignored until IDLE.
REQ-024 rst pulsed during the MSTATUS write: all outputs 0 the same cycle; after release, IDLE with no further writes.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared CLINT definitions: CSR addresses, system instruction encodings,
// mcause codes and the trap sequencer state encoding.
package clint_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  // Trap kind and write step share one register: SYNC/ASYNC each walk
  // MEPC -> MSTATUS -> MCAUSE -> ASSERT, MRET walks MSTATUS -> ASSERT.
  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_SYNC_MEPC     = 4'd1,
    ST_SYNC_MSTATUS  = 4'd2,
    ST_SYNC_MCAUSE   = 4'd3,
    ST_SYNC_ASSERT   = 4'd4,
    ST_ASYNC_MEPC    = 4'd5,
    ST_ASYNC_MSTATUS = 4'd6,
    ST_ASYNC_MCAUSE  = 4'd7,
    ST_ASYNC_ASSERT  = 4'd8,
    ST_MRET_MSTATUS  = 4'd9,
    ST_MRET_ASSERT   = 4'd10
  } state_e;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    return {m[31:8], m[3], m[6:4], 1'b0, m[2:0]};
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    return {m[31:8], 1'b1, m[6:4], m[7], m[2:0]};
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interruptor: sequences CSR writes for ecall/ebreak/async
// interrupt entry and mret return, then redirects the pipeline.
module clint
  import clint_pkg::*;
#(
  parameter int INT_FLAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INT_FLAG_W-1:0] int_flag_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           inst_addr_i,
  input  logic                  jump_flag_i,
  input  logic [31:0]           jump_addr_i,
  input  logic                  div_started_i,
  input  logic [31:0]           csr_mtvec_i,
  input  logic [31:0]           csr_mepc_i,
  input  logic [31:0]           csr_mstatus_i,
  input  logic                  global_int_en_i,
  output logic                  hold_flag_o,
  output logic                  we_o,
  output logic [31:0]           waddr_o,
  output logic [31:0]           raddr_o,
  output logic [31:0]           data_o,
  output logic                  int_assert_o,
  output logic [31:0]           int_addr_o
);

  state_e      r_state, w_next;
  logic [31:0] r_pc, r_cause;
  logic [31:0] w_pc, w_cause;

  logic        w_ecall, w_ebreak, w_mret, w_async_req;
  logic        w_hold, w_we, w_assert;
  logic [11:0] w_waddr;
  logic [31:0] w_data, w_iaddr;

  assign w_ecall     = (inst_i == INST_ECALL);
  assign w_ebreak    = (inst_i == INST_EBREAK);
  assign w_mret      = (inst_i == INST_MRET);
  // A request held off by a divide is simply re-evaluated each cycle.
  assign w_async_req = (|int_flag_i) && global_int_en_i && !div_started_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc;
      r_cause <= w_cause;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pc     = r_pc;
    w_cause  = r_cause;
    w_hold   = 1'b1;
    w_we     = 1'b0;
    w_waddr  = 12'h000;
    w_data   = '0;
    w_assert = 1'b0;
    w_iaddr  = '0;
    case (r_state)
      ST_IDLE: begin
        w_hold = 1'b0;
        if (w_ecall || w_ebreak) begin
          w_hold  = 1'b1;
          w_next  = ST_SYNC_MEPC;
          w_pc    = inst_addr_i;
          w_cause = w_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
        end else if (w_mret) begin
          w_hold = 1'b1;
          w_next = ST_MRET_MSTATUS;
        end else if (w_async_req) begin
          w_hold  = 1'b1;
          w_next  = ST_ASYNC_MEPC;
          w_pc    = jump_flag_i ? jump_addr_i : inst_addr_i;
          w_cause = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
        end
      end
      ST_SYNC_MEPC, ST_ASYNC_MEPC: begin
        w_we    = 1'b1;
        w_waddr = CSR_MEPC;
        w_data  = r_pc;
        w_next  = (r_state == ST_SYNC_MEPC) ? ST_SYNC_MSTATUS : ST_ASYNC_MSTATUS;
      end
      ST_SYNC_MSTATUS, ST_ASYNC_MSTATUS: begin
        w_we    = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_data  = trap_mstatus(csr_mstatus_i);
        w_next  = (r_state == ST_SYNC_MSTATUS) ? ST_SYNC_MCAUSE : ST_ASYNC_MCAUSE;
      end
      ST_SYNC_MCAUSE, ST_ASYNC_MCAUSE: begin
        w_we    = 1'b1;
        w_waddr = CSR_MCAUSE;
        w_data  = r_cause;
        w_next  = (r_state == ST_SYNC_MCAUSE) ? ST_SYNC_ASSERT : ST_ASYNC_ASSERT;
      end
      ST_SYNC_ASSERT, ST_ASYNC_ASSERT: begin
        w_assert = 1'b1;
        w_iaddr  = csr_mtvec_i;
        w_next   = ST_IDLE;
      end
      ST_MRET_MSTATUS: begin
        w_we    = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_data  = mret_mstatus(csr_mstatus_i);
        w_next  = ST_MRET_ASSERT;
      end
      ST_MRET_ASSERT: begin
        w_assert = 1'b1;
        w_iaddr  = csr_mepc_i;
        w_next   = ST_IDLE;
      end
      default: begin
        w_hold = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  // Reset wins over the IDLE trigger decode so nothing leaks out while held.
  assign hold_flag_o  = w_hold & ~rst;
  assign we_o         = w_we & ~rst;
  assign waddr_o      = rst ? 32'h0 : {20'h0, w_waddr};
  assign raddr_o      = '0;
  assign data_o       = rst ? 32'h0 : w_data;
  assign int_assert_o = w_assert & ~rst;
  assign int_addr_o   = rst ? 32'h0 : w_iaddr;

endmodule

// File: tb/tb_clint.sv
// Randomized scoreboard bench for clint: a trap-level model queues the
// expected CSR writes / redirects with their cycle, a monitor checks them.
module tb_clint;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, div_started_i, global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, raddr_o, data_o, int_addr_o;

  clint #(.INT_FLAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .int_flag_i(int_flag_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .div_started_i(div_started_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .global_int_en_i(global_int_en_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .raddr_o(raddr_o),
    .data_o(data_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        ia;
    logic [31:0] iaddr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   busy_until = 0;
  int   checks = 0;
  int   failures = 0;
  logic exp_hold = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic push_ev(input int c, input logic we, input logic [31:0] a, d,
                         input logic ia, input logic [31:0] ta);
    exp_t e;
    e.cyc = c; e.we = we; e.waddr = a; e.data = d; e.ia = ia; e.iaddr = ta;
    q.push_back(e);
  endtask

  // Trap entry: three CSR writes then a redirect to mtvec.
  task automatic model_trap(input logic [31:0] epc, cause);
    logic [31:0] ms;
    ms = (csr_mstatus_i & ~32'h88) | ((csr_mstatus_i & 32'h8) << 4);
    push_ev(cyc + 1, 1'b1, 32'h341, epc, 1'b0, 0);
    push_ev(cyc + 2, 1'b1, 32'h300, ms, 1'b0, 0);
    push_ev(cyc + 3, 1'b1, 32'h342, cause, 1'b0, 0);
    push_ev(cyc + 4, 1'b0, 0, 0, 1'b1, csr_mtvec_i);
    busy_until = cyc + 5;
    exp_hold = 1'b1;
  endtask

  task automatic step(input logic [31:0] inst, pc, input logic [7:0] flg,
                      input logic jf, input logic [31:0] ja, input logic div, mie,
                      input logic [31:0] mtvec, mepc, mst);
    logic idle;
    logic [31:0] ms;
    @(posedge clk); #1;
    idle = (cyc >= busy_until);
    inst_i = inst; inst_addr_i = pc; int_flag_i = flg; jump_flag_i = jf;
    jump_addr_i = ja; div_started_i = div; global_int_en_i = mie;
    if (idle) begin
      csr_mtvec_i = mtvec; csr_mepc_i = mepc; csr_mstatus_i = mst;
    end
    exp_hold = !idle;
    if (idle) begin
      if (inst == ECALL || inst == EBREAK) begin
        model_trap(pc, (inst == ECALL) ? 32'd11 : 32'd3);
      end else if (inst == MRET) begin
        ms = (csr_mstatus_i & ~32'h8) | ((csr_mstatus_i >> 4) & 32'h8) | 32'h80;
        push_ev(cyc + 1, 1'b1, 32'h300, ms, 1'b0, 0);
        push_ev(cyc + 2, 1'b0, 0, 0, 1'b1, csr_mepc_i);
        busy_until = cyc + 3;
        exp_hold = 1'b1;
      end else if (flg != 0 && mie && !div) begin
        model_trap(jf ? ja : pc, flg[0] ? 32'h8000_0007 : 32'h8000_000B);
      end
    end
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(NOP, $urandom, 8'h00, 1'b0, $urandom, 1'b0, 1'b1,
                    csr_mtvec_i, csr_mepc_i, csr_mstatus_i);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (hold_flag_o !== exp_hold) begin
        failures++;
        $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, hold_flag_o, exp_hold);
      end
      checks++;
      if (raddr_o !== 32'h0) begin
        failures++;
        $display("FAIL raddr cyc=%0d got=%h exp=0", cyc, raddr_o);
      end
      if (rst) begin
        checks++;
        if (we_o !== 1'b0 || int_assert_o !== 1'b0 || waddr_o !== 0 || data_o !== 0
            || int_addr_o !== 0) begin
          failures++;
          $display("FAIL reset_outs cyc=%0d we=%b ia=%b wa=%h d=%h ta=%h exp all 0",
                   cyc, we_o, int_assert_o, waddr_o, data_o, int_addr_o);
        end
      end else if (we_o === 1'b1 || int_assert_o === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected cyc=%0d we=%b wa=%h d=%h ia=%b ta=%h exp none",
                   cyc, we_o, waddr_o, data_o, int_assert_o, int_addr_o);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || we_o !== e.we || waddr_o !== e.waddr || data_o !== e.data
              || int_assert_o !== e.ia || int_addr_o !== e.iaddr) begin
            failures++;
            $display("FAIL event got cyc=%0d we=%b wa=%h d=%h ia=%b ta=%h exp cyc=%0d we=%b wa=%h d=%h ia=%b ta=%h",
                     cyc, we_o, waddr_o, data_o, int_assert_o, int_addr_o,
                     e.cyc, e.we, e.waddr, e.data, e.ia, e.iaddr);
          end
        end
      end else begin
        checks++;
        if (waddr_o !== 0 || data_o !== 0 || int_addr_o !== 0 || we_o !== 1'b0
            || int_assert_o !== 1'b0) begin
          failures++;
          $display("FAIL idle_zero cyc=%0d wa=%h d=%h ta=%h exp 0", cyc, waddr_o, data_o, int_addr_o);
        end
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          checks++;
          failures++;
          e = q.pop_front();
          $display("FAIL missing cyc=%0d exp wa=%h d=%h ia=%b ta=%h got nothing",
                   cyc, e.waddr, e.data, e.ia, e.iaddr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; inst_i = NOP; inst_addr_i = 0; int_flag_i = 0; jump_flag_i = 0;
    jump_addr_i = 0; div_started_i = 0; global_int_en_i = 0;
    csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
    #1 mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_n(2);

    // ecall at 0x100, mtvec 0x200, mstatus 0x8
    step(ECALL, 32'h100, 8'h00, 1'b0, 0, 1'b0, 1'b1, 32'h200, 32'h0, 32'h8);
    idle_n(6);
    // timer interrupt with redirect in flight, then external without
    step(NOP, 32'h500, 8'h01, 1'b1, 32'h340, 1'b0, 1'b1, 32'h200, 32'h0, 32'h8);
    idle_n(5);
    step(NOP, 32'h504, 8'h04, 1'b0, 32'h999, 1'b0, 1'b1, 32'h200, 32'h0, 32'h8);
    idle_n(5);
    // mret with mstatus 0x80, mepc 0x104
    step(MRET, 32'h600, 8'h00, 1'b0, 0, 1'b0, 1'b1, 32'h200, 32'h104, 32'h80);
    idle_n(3);
    // divide blocks the request; dropping it lets the request in
    repeat (5) step(NOP, 32'h700, 8'h02, 1'b0, 0, 1'b1, 1'b1, 32'h300, 32'h0, 32'h8);
    step(NOP, 32'h704, 8'h02, 1'b0, 0, 1'b0, 1'b1, 32'h300, 32'h0, 32'h8);
    idle_n(5);
    repeat (5) step(NOP, 32'h708, 8'h02, 1'b0, 0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h8);
    idle_n(2);
    // ecall beats a simultaneous interrupt, which waits until IDLE
    step(ECALL, 32'h800, 8'h05, 1'b0, 0, 1'b0, 1'b1, 32'h400, 32'h0, 32'h88);
    repeat (4) step(NOP, 32'h804, 8'h05, 1'b0, 0, 1'b0, 1'b1, 32'h400, 32'h0, 32'h88);
    idle_n(6);
    // reset during the MSTATUS write
    step(EBREAK, 32'h900, 8'h00, 1'b0, 0, 1'b0, 1'b1, 32'h500, 32'h0, 32'h8);
    idle_n(1);
    @(posedge clk); #1;
    rst = 1'b1; inst_i = NOP; int_flag_i = 0;
    q.delete(); busy_until = 0; exp_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_n(6);

    repeat (400) begin
      logic [31:0] inst;
      logic [7:0]  flg;
      int r;
      r = $urandom_range(0, 9);
      inst = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r == 2) ? MRET : $urandom;
      flg = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(inst, $urandom, flg, 1'($urandom), $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom);
    end
    idle_n(8);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
